touch_thr_ctrl: RTL and testbench

TOUCH_THR_CTRL -- requirements
Module: touch_thr_ctrl

---
 rtl/touch_ctrl_pkg.sv | 96 +++++++++
 rtl/touch_div16.sv | 74 +++++++
 rtl/touch_thr_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_touch_thr_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/touch_ctrl_pkg.sv
// Shared types, screen geometry and reset values for the touch threshold controller.
// Regions are open intervals: a coordinate exactly on a boundary never hits.
package touch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        CLASSIFY,
        DIVIDE,
        COMMIT,
        WAIT_RELEASE
    } state_e;

    typedef enum logic [2:0] {
        NONE,
        Y_UP,
        Y_DN,
        CB_UP,
        CB_DN,
        CR_UP,
        CR_DN,
        MOTOR
    } region_e;

    localparam logic [15:0] COL_Y_X  = 16'h0293;
    localparam logic [15:0] COL_CB_X = 16'h02C7;
    localparam logic [15:0] COL_CR_X = 16'h0311;
    localparam logic [15:0] COL_HALF = 16'd10;

    localparam logic [15:0] UP_LO = 16'h0027;
    localparam logic [15:0] UP_HI = 16'h00D8;
    localparam logic [15:0] DN_LO = 16'h0109;
    localparam logic [15:0] DN_HI = 16'h01C8;

    localparam logic [15:0] MOT_X    = 16'h0053;
    localparam logic [15:0] MOT_Y    = 16'h01C3;
    localparam logic [15:0] MOT_HALF = 16'd30;

    localparam logic [15:0] DIV_UP = 16'h00B1;
    localparam logic [15:0] DIV_DN = 16'h00BF;

    localparam logic [7:0] RST_Y_UP  = 8'hFF;
    localparam logic [7:0] RST_Y_DN  = 8'h00;
    localparam logic [7:0] RST_CB_UP = 8'hFF;
    localparam logic [7:0] RST_CB_DN = 8'h80;
    localparam logic [7:0] RST_CR_UP = 8'hFF;
    localparam logic [7:0] RST_CR_DN = 8'h80;

    function automatic logic in_open(input logic [15:0] v, input logic [15:0] lo,
                                     input logic [15:0] hi);
        return (v > lo) && (v < hi);
    endfunction

    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic is_up(input region_e r);
        return (r == Y_UP) || (r == CB_UP) || (r == CR_UP);
    endfunction

    function automatic region_e classify(input logic [15:0] x, input logic [15:0] y);
        logic up;
        logic dn;
        region_e r;
        up = in_open(y, UP_LO, UP_HI);
        dn = in_open(y, DN_LO, DN_HI);
        r  = NONE;
        if (in_open(x, MOT_X - MOT_HALF, MOT_X + MOT_HALF) &&
            in_open(y, MOT_Y - MOT_HALF, MOT_Y + MOT_HALF)) begin
            r = MOTOR;
        end else if (in_open(x, COL_Y_X - COL_HALF, COL_Y_X + COL_HALF)) begin
            if (up)      r = Y_UP;
            else if (dn) r = Y_DN;
        end else if (in_open(x, COL_CB_X - COL_HALF, COL_CB_X + COL_HALF)) begin
            if (up)      r = CB_UP;
            else if (dn) r = CB_DN;
        end else if (in_open(x, COL_CR_X - COL_HALF, COL_CR_X + COL_HALF)) begin
            if (up)      r = CR_UP;
            else if (dn) r = CR_DN;
        end
        return r;
    endfunction

    // Slider travel scaled to 0..255: distance from the band's far end times 255.
    function automatic logic [15:0] slider_num(input region_e r, input logic [15:0] y);
        logic [15:0] d;
        d = is_up(r) ? (UP_HI - y) : (DN_HI - y);
        return (d << 8) - d;
    endfunction

    function automatic logic [15:0] slider_den(input region_e r);
        return is_up(r) ? DIV_UP : DIV_DN;
    endfunction

endpackage

// File: rtl/touch_div16.sv
// Sequential restoring unsigned 16/16 divider, one quotient bit per cycle.
// The first bit is resolved on the start edge; done pulses 16 cycles after start.
module touch_div16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] num_i,
    input  logic [15:0] den_i,
    output logic        done_o,
    output logic [7:0]  quo_o
);

    logic [15:0] rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] den_q;
    logic [3:0]  cnt_q;
    logic        run_q;
    logic        done_q;

    logic [15:0] rem_in;
    logic [15:0] quo_in;
    logic [15:0] den_use;
    logic [16:0] trial;
    logic        q_bit;

    // A start overrides any division in flight, so the step always works from the new operands.
    always_comb begin
        rem_in  = start_i ? 16'd0 : rem_q;
        quo_in  = start_i ? num_i : quo_q;
        den_use = start_i ? den_i : den_q;
        trial   = {rem_in, quo_in[15]};
        q_bit   = 1'b0;
        rem_d   = trial[15:0];
        if (trial >= {1'b0, den_use}) begin
            q_bit = 1'b1;
            rem_d = 16'(trial - {1'b0, den_use});
        end
        quo_d = {quo_in[14:0], q_bit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= 16'd0;
            quo_q  <= 16'd0;
            den_q  <= 16'd0;
            cnt_q  <= 4'd0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                den_q <= den_i;
                cnt_q <= 4'd1;
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                if (cnt_q == 4'd15) begin
                    cnt_q  <= 4'd0;
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign quo_o  = quo_q[7:0];

endmodule

// File: rtl/touch_thr_ctrl.sv
// Touch-panel front end: debounces presses, maps slider hits to 8-bit thresholds, pulses motor reset.
// Define TOUCH_DRAG_EN to let a held finger dragging along the same slider re-commit new values.
module touch_thr_ctrl
    import touch_ctrl_pkg::*;
#(
    parameter int DEB_CNT = 4,
    parameter int TOL     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        touch_valid,
    input  logic        touch_down,
    input  logic [31:0] touch_data,
    output logic [7:0]  thr_y_up,
    output logic [7:0]  thr_y_down,
    output logic [7:0]  thr_cb_up,
    output logic [7:0]  thr_cb_down,
    output logic [7:0]  thr_cr_up,
    output logic [7:0]  thr_cr_down,
    output logic        thr_update,
    output logic        motor_reset,
    output logic        busy
);

    localparam logic [3:0]  DEB   = 4'(DEB_CNT);
    localparam logic [15:0] TOL_V = 16'(TOL);

    state_e      state_q, state_d;
    region_e     region_q, region_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] x_ref_q, x_ref_d, y_ref_q, y_ref_d;
    logic [15:0] cls_x_q, cls_x_d, cls_y_q, cls_y_d;
    logic        release_pend_q, release_pend_d;
    logic [7:0]  y_up_q, y_up_d, y_dn_q, y_dn_d;
    logic [7:0]  cb_up_q, cb_up_d, cb_dn_q, cb_dn_d;
    logic [7:0]  cr_up_q, cr_up_d, cr_dn_q, cr_dn_d;
    logic        thr_update_q, thr_update_d;
    logic        motor_reset_q, motor_reset_d;
`ifdef TOUCH_DRAG_EN
    logic [15:0] y_last_q, y_last_d;
    region_e     last_region_q, last_region_d;
    region_e     smp_region;
`endif

    logic        smp_v_q, smp_dn_q;
    logic [15:0] smp_x_q, smp_y_q;

    logic        rel_seen, dn_seen;
    region_e     cls_region;
    logic        div_start;
    logic [15:0] div_num, div_den;
    logic        div_done;
    logic [7:0]  div_quo;

    touch_div16 u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .num_i   (div_num),
        .den_i   (div_den),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );

    // Samples are registered once so the FSM only ever sees flopped inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_v_q  <= 1'b0;
            smp_dn_q <= 1'b0;
            smp_x_q  <= 16'd0;
            smp_y_q  <= 16'd0;
        end else begin
            smp_v_q  <= touch_valid;
            smp_dn_q <= touch_down;
            smp_x_q  <= touch_data[31:16];
            smp_y_q  <= touch_data[15:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        region_d       = region_q;
        cnt_d          = cnt_q;
        x_ref_d        = x_ref_q;
        y_ref_d        = y_ref_q;
        cls_x_d        = cls_x_q;
        cls_y_d        = cls_y_q;
        release_pend_d = release_pend_q;
        y_up_d         = y_up_q;
        y_dn_d         = y_dn_q;
        cb_up_d        = cb_up_q;
        cb_dn_d        = cb_dn_q;
        cr_up_d        = cr_up_q;
        cr_dn_d        = cr_dn_q;
        thr_update_d   = 1'b0;
        motor_reset_d  = 1'b0;
        div_start      = 1'b0;
        div_num        = 16'd0;
        div_den        = 16'd0;
        rel_seen       = smp_v_q && !smp_dn_q;
        dn_seen        = smp_v_q && smp_dn_q;
        cls_region     = classify(cls_x_q, cls_y_q);
`ifdef TOUCH_DRAG_EN
        y_last_d       = y_last_q;
        last_region_d  = last_region_q;
        smp_region     = classify(smp_x_q, smp_y_q);
`endif

        case (state_q)
            IDLE: begin
                if (dn_seen) begin
                    x_ref_d = smp_x_q;
                    y_ref_d = smp_y_q;
                    cls_x_d = smp_x_q;
                    cls_y_d = smp_y_q;
                    cnt_d   = 4'd1;
                    state_d = (DEB == 4'd1) ? CLASSIFY : DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (rel_seen) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (dn_seen) begin
                    if (abs_diff(smp_x_q, x_ref_q) <= TOL_V &&
                        abs_diff(smp_y_q, y_ref_q) <= TOL_V) begin
                        cnt_d   = cnt_q + 4'd1;
                        cls_x_d = smp_x_q;
                        cls_y_d = smp_y_q;
                        if (cnt_q + 4'd1 == DEB) begin
                            cnt_d   = 4'd0;
                            state_d = CLASSIFY;
                        end
                    end else begin
                        x_ref_d = smp_x_q;
                        y_ref_d = smp_y_q;
                        cnt_d   = 4'd1;
                    end
                end
            end

            CLASSIFY: begin
                region_d = cls_region;
                if (rel_seen) release_pend_d = 1'b1;
                if (cls_region == MOTOR) begin
                    state_d = COMMIT;
                end else if (cls_region == NONE) begin
                    // A release already seen would otherwise strand us in WAIT_RELEASE.
                    release_pend_d = 1'b0;
                    state_d = (release_pend_q || rel_seen) ? IDLE : WAIT_RELEASE;
                end else begin
                    div_start = 1'b1;
                    div_num   = slider_num(cls_region, cls_y_q);
                    div_den   = slider_den(cls_region);
                    state_d   = DIVIDE;
                end
            end

            DIVIDE: begin
                if (rel_seen) release_pend_d = 1'b1;
                if (div_done) state_d = COMMIT;
            end

            COMMIT: begin
                thr_update_d = (region_q != MOTOR) && (region_q != NONE);
                case (region_q)
                    Y_UP:    y_up_d  = div_quo;
                    Y_DN:    y_dn_d  = div_quo;
                    CB_UP:   cb_up_d = div_quo;
                    CB_DN:   cb_dn_d = div_quo;
                    CR_UP:   cr_up_d = div_quo;
                    CR_DN:   cr_dn_d = div_quo;
                    MOTOR:   motor_reset_d = 1'b1;
                    default: ;
                endcase
`ifdef TOUCH_DRAG_EN
                y_last_d      = cls_y_q;
                last_region_d = region_q;
`endif
                release_pend_d = 1'b0;
                state_d = (release_pend_q || rel_seen) ? IDLE : WAIT_RELEASE;
            end

            WAIT_RELEASE: begin
                if (rel_seen) begin
                    state_d = IDLE;
`ifdef TOUCH_DRAG_EN
                end else if (dn_seen && last_region_q != MOTOR && last_region_q != NONE &&
                             smp_region == last_region_q &&
                             abs_diff(smp_y_q, y_last_q) > TOL_V) begin
                    cls_x_d = smp_x_q;
                    cls_y_d = smp_y_q;
                    state_d = CLASSIFY;
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            region_q       <= NONE;
            cnt_q          <= 4'd0;
            x_ref_q        <= 16'd0;
            y_ref_q        <= 16'd0;
            cls_x_q        <= 16'd0;
            cls_y_q        <= 16'd0;
            release_pend_q <= 1'b0;
            y_up_q         <= RST_Y_UP;
            y_dn_q         <= RST_Y_DN;
            cb_up_q        <= RST_CB_UP;
            cb_dn_q        <= RST_CB_DN;
            cr_up_q        <= RST_CR_UP;
            cr_dn_q        <= RST_CR_DN;
            thr_update_q   <= 1'b0;
            motor_reset_q  <= 1'b0;
`ifdef TOUCH_DRAG_EN
            y_last_q       <= 16'd0;
            last_region_q  <= NONE;
`endif
        end else begin
            state_q        <= state_d;
            region_q       <= region_d;
            cnt_q          <= cnt_d;
            x_ref_q        <= x_ref_d;
            y_ref_q        <= y_ref_d;
            cls_x_q        <= cls_x_d;
            cls_y_q        <= cls_y_d;
            release_pend_q <= release_pend_d;
            y_up_q         <= y_up_d;
            y_dn_q         <= y_dn_d;
            cb_up_q        <= cb_up_d;
            cb_dn_q        <= cb_dn_d;
            cr_up_q        <= cr_up_d;
            cr_dn_q        <= cr_dn_d;
            thr_update_q   <= thr_update_d;
            motor_reset_q  <= motor_reset_d;
`ifdef TOUCH_DRAG_EN
            y_last_q       <= y_last_d;
            last_region_q  <= last_region_d;
`endif
        end
    end

    assign thr_y_up    = y_up_q;
    assign thr_y_down  = y_dn_q;
    assign thr_cb_up   = cb_up_q;
    assign thr_cb_down = cb_dn_q;
    assign thr_cr_up   = cr_up_q;
    assign thr_cr_down = cr_dn_q;
    assign thr_update  = thr_update_q;
    assign motor_reset = motor_reset_q;
    assign busy        = (state_q == CLASSIFY) || (state_q == DIVIDE) || (state_q == COMMIT);

endmodule

// File: tb/tb_touch_thr_ctrl.sv
// Directed bench for touch_thr_ctrl: debounce, slider scaling, motor pulse, latency and reset.
// Drag tracking scenario is compiled only when TOUCH_DRAG_EN is defined.
module tb_touch_thr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        touch_valid = 1'b0;
    logic        touch_down = 1'b0;
    logic [31:0] touch_data = 32'd0;
    logic [7:0]  thr_y_up, thr_y_down, thr_cb_up, thr_cb_down, thr_cr_up, thr_cr_down;
    logic        thr_update, motor_reset, busy;

    int total = 0;
    int bad = 0;
    int upd_cnt = 0;
    int mot_cnt = 0;

    touch_thr_ctrl #(.DEB_CNT(4), .TOL(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .touch_valid (touch_valid),
        .touch_down  (touch_down),
        .touch_data  (touch_data),
        .thr_y_up    (thr_y_up),
        .thr_y_down  (thr_y_down),
        .thr_cb_up   (thr_cb_up),
        .thr_cb_down (thr_cb_down),
        .thr_cr_up   (thr_cr_up),
        .thr_cr_down (thr_cr_down),
        .thr_update  (thr_update),
        .motor_reset (motor_reset),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (thr_update === 1'b1) upd_cnt++;
        if (motor_reset === 1'b1) mot_cnt++;
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sample; the second posedge is the edge that captures it.
    task automatic send(input logic dn, input logic [15:0] x, input logic [15:0] y);
        @(posedge clk);
        #1;
        touch_valid = 1'b1;
        touch_down  = dn;
        touch_data  = {x, y};
        @(posedge clk);
        #1;
        touch_valid = 1'b0;
        touch_down  = 1'b0;
    endtask

    task automatic press(input logic [15:0] x, input logic [15:0] y, input int n);
        for (int i = 0; i < n; i++) send(1'b1, x, y);
    endtask

    task automatic test_reset();
        wait_edges(2);
        total++; if (thr_y_up !== 8'hFF) begin bad++; $display("FAIL rst_y_up got=%0h exp=ff", thr_y_up); end
        total++; if (thr_y_down !== 8'h00) begin bad++; $display("FAIL rst_y_down got=%0h exp=0", thr_y_down); end
        total++; if (thr_cb_up !== 8'hFF) begin bad++; $display("FAIL rst_cb_up got=%0h exp=ff", thr_cb_up); end
        total++; if (thr_cb_down !== 8'h80) begin bad++; $display("FAIL rst_cb_down got=%0h exp=80", thr_cb_down); end
        total++; if (thr_cr_up !== 8'hFF) begin bad++; $display("FAIL rst_cr_up got=%0h exp=ff", thr_cr_up); end
        total++; if (thr_cr_down !== 8'h80) begin bad++; $display("FAIL rst_cr_down got=%0h exp=80", thr_cr_down); end
        total++; if (thr_update !== 1'b0) begin bad++; $display("FAIL rst_thr_update got=%0b exp=0", thr_update); end
        total++; if (motor_reset !== 1'b0) begin bad++; $display("FAIL rst_motor_reset got=%0b exp=0", motor_reset); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        rst = 1'b0;
        wait_edges(2);
    endtask

    task automatic test_slider_y_up();
        int u0;
        u0 = upd_cnt;
        press(16'h0293, 16'h0070, 4);
        wait_edges(18);
        total++; if (thr_y_up !== 8'hFF) begin bad++; $display("FAIL y_up_early got=%0h exp=ff", thr_y_up); end
        total++; if (thr_update !== 1'b0) begin bad++; $display("FAIL y_up_pulse_early got=%0b exp=0", thr_update); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL y_up_busy got=%0b exp=1", busy); end
        wait_edges(1);
        total++; if (thr_y_up !== 8'h95) begin bad++; $display("FAIL y_up_value got=%0h exp=95", thr_y_up); end
        total++; if (thr_update !== 1'b1) begin bad++; $display("FAIL y_up_pulse got=%0b exp=1", thr_update); end
        wait_edges(1);
        total++; if (thr_update !== 1'b0) begin bad++; $display("FAIL y_up_pulse_end got=%0b exp=0", thr_update); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL y_up_idle got=%0b exp=0", busy); end
        total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL y_up_count got=%0d exp=1", upd_cnt - u0); end
        send(1'b0, 16'h0293, 16'h0070);
    endtask

    task automatic test_cb_down();
        press(16'h02C7, 16'h0150, 4);
        wait_edges(19);
        total++; if (thr_cb_down !== 8'hA0) begin bad++; $display("FAIL cb_down_value got=%0h exp=a0", thr_cb_down); end
        total++; if (thr_update !== 1'b1) begin bad++; $display("FAIL cb_down_pulse got=%0b exp=1", thr_update); end
        total++; if (thr_y_up !== 8'h95) begin bad++; $display("FAIL cb_keep_y_up got=%0h exp=95", thr_y_up); end
        total++; if (thr_y_down !== 8'h00) begin bad++; $display("FAIL cb_keep_y_down got=%0h exp=0", thr_y_down); end
        total++; if (thr_cb_up !== 8'hFF) begin bad++; $display("FAIL cb_keep_cb_up got=%0h exp=ff", thr_cb_up); end
        total++; if (thr_cr_up !== 8'hFF) begin bad++; $display("FAIL cb_keep_cr_up got=%0h exp=ff", thr_cr_up); end
        total++; if (thr_cr_down !== 8'h80) begin bad++; $display("FAIL cb_keep_cr_down got=%0h exp=80", thr_cr_down); end
        wait_edges(1);
        send(1'b0, 16'h02C7, 16'h0150);
    endtask

    task automatic test_motor();
        int u0;
        int m0;
        u0 = upd_cnt;
        m0 = mot_cnt;
        press(16'h0053, 16'h01C3, 4);
        wait_edges(2);
        total++; if (motor_reset !== 1'b0) begin bad++; $display("FAIL motor_early got=%0b exp=0", motor_reset); end
        wait_edges(1);
        total++; if (motor_reset !== 1'b1) begin bad++; $display("FAIL motor_pulse got=%0b exp=1", motor_reset); end
        press(16'h0053, 16'h01C3, 6);
        wait_edges(5);
        total++; if (mot_cnt - m0 !== 1) begin bad++; $display("FAIL motor_count got=%0d exp=1", mot_cnt - m0); end
        total++; if (upd_cnt !== u0) begin bad++; $display("FAIL motor_no_update got=%0d exp=%0d", upd_cnt, u0); end
        send(1'b0, 16'h0053, 16'h01C3);
    endtask

    task automatic test_debounce_restart();
        int u0;
        u0 = upd_cnt;
        press(16'h0311, 16'h0050, 3);
        send(1'b1, 16'h0311, 16'h0064);
        press(16'h0311, 16'h0050, 2);
        wait_edges(25);
        total++; if (upd_cnt !== u0) begin bad++; $display("FAIL deb_no_update got=%0d exp=%0d", upd_cnt, u0); end
        total++; if (thr_cr_up !== 8'hFF) begin bad++; $display("FAIL deb_cr_up got=%0h exp=ff", thr_cr_up); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL deb_busy got=%0b exp=0", busy); end
        send(1'b0, 16'h0311, 16'h0050);
    endtask

    task automatic test_band_edge();
        int u0;
        u0 = upd_cnt;
        press(16'h0293, 16'h0027, 4);
        wait_edges(25);
        total++; if (upd_cnt !== u0) begin bad++; $display("FAIL edge_lo_no_update got=%0d exp=%0d", upd_cnt, u0); end
        total++; if (thr_y_up !== 8'h95) begin bad++; $display("FAIL edge_lo_y_up got=%0h exp=95", thr_y_up); end
        send(1'b0, 16'h0293, 16'h0027);
        press(16'h0293, 16'h00D8, 4);
        wait_edges(25);
        total++; if (upd_cnt !== u0) begin bad++; $display("FAIL edge_hi_no_update got=%0d exp=%0d", upd_cnt, u0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL edge_hi_busy got=%0b exp=0", busy); end
        send(1'b0, 16'h0293, 16'h00D8);
    endtask

    task automatic test_release_pend();
        int u0;
        u0 = upd_cnt;
        press(16'h0293, 16'h0050, 4);
        wait_edges(4);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL pend_busy got=%0b exp=1", busy); end
        send(1'b0, 16'h0293, 16'h0050);
        wait_edges(20);
        total++; if (thr_y_up !== 8'hC3) begin bad++; $display("FAIL pend_y_up got=%0h exp=c3", thr_y_up); end
        total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL pend_count got=%0d exp=1", upd_cnt - u0); end
        press(16'h0293, 16'h00A0, 4);
        wait_edges(20);
        total++; if (thr_y_up !== 8'h50) begin bad++; $display("FAIL pend_next_y_up got=%0h exp=50", thr_y_up); end
        total++; if (upd_cnt - u0 !== 2) begin bad++; $display("FAIL pend_next_count got=%0d exp=2", upd_cnt - u0); end
        send(1'b0, 16'h0293, 16'h00A0);
    endtask

`ifdef TOUCH_DRAG_EN
    task automatic test_drag();
        int u0;
        u0 = upd_cnt;
        press(16'h0293, 16'h0070, 4);
        wait_edges(20);
        total++; if (thr_y_up !== 8'h95) begin bad++; $display("FAIL drag_first got=%0h exp=95", thr_y_up); end
        send(1'b1, 16'h0293, 16'h0090);
        wait_edges(20);
        total++; if (thr_y_up !== 8'h67) begin bad++; $display("FAIL drag_second got=%0h exp=67", thr_y_up); end
        total++; if (upd_cnt - u0 !== 2) begin bad++; $display("FAIL drag_count got=%0d exp=2", upd_cnt - u0); end
        send(1'b0, 16'h0293, 16'h0090);
    endtask
`endif

    task automatic test_reset_mid_divide();
        int u0;
        u0 = upd_cnt;
        press(16'h02C7, 16'h0050, 4);
        wait_edges(8);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%0b exp=1", busy); end
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b exp=0", busy); end
        total++; if (thr_update !== 1'b0) begin bad++; $display("FAIL mid_thr_update got=%0b exp=0", thr_update); end
        total++; if (motor_reset !== 1'b0) begin bad++; $display("FAIL mid_motor got=%0b exp=0", motor_reset); end
        total++; if (thr_y_up !== 8'hFF) begin bad++; $display("FAIL mid_y_up got=%0h exp=ff", thr_y_up); end
        total++; if (thr_cb_down !== 8'h80) begin bad++; $display("FAIL mid_cb_down got=%0h exp=80", thr_cb_down); end
        wait_edges(1);
        rst = 1'b0;
        wait_edges(25);
        total++; if (upd_cnt !== u0) begin bad++; $display("FAIL mid_no_update got=%0d exp=%0d", upd_cnt, u0); end
        total++; if (thr_cb_up !== 8'hFF) begin bad++; $display("FAIL mid_cb_up got=%0h exp=ff", thr_cb_up); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after got=%0b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_slider_y_up();
        test_cb_down();
        test_motor();
        test_debounce_restart();
        test_band_edge();
        test_release_pend();
`ifdef TOUCH_DRAG_EN
        test_drag();
`endif
        test_reset_mid_divide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
